// File: rtl/ds_pkt_pkg.sv
// Shared types and payload layout for the periodic data-stream packetizer.
// Each beat carries a 32-bit header word in its low bits. All higher data bits are zero.
package ds_pkt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int SEQ_LSB  = 0;
    localparam int BEAT_LSB = 8;
    localparam int MARK_LSB = 12;
    localparam int CNT_LSB  = 16;

    localparam logic [3:0] MARKER = 4'hA;

    function automatic logic [31:0] beat_word(
        input logic [7:0]  seq,
        input logic [3:0]  beat,
        input logic [15:0] cnt
    );
        logic [31:0] w;
        w = '0;
        w[SEQ_LSB  +: 8]  = seq;
        w[BEAT_LSB +: 4]  = beat;
        w[MARK_LSB +: 4]  = MARKER;
        w[CNT_LSB  +: 16] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/ds_period_timer.sv
// Free-running period counter. It is held at zero while disabled.
// o_tick is high for the single cycle in which the count sits at PERIOD_CYCLES-1.
module ds_period_timer #(
    parameter int PERIOD_CYCLES = 1000
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_enable,
    output logic o_tick
);
    localparam int CW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);
    assign o_tick    = i_enable & w_at_last;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_count <= '0;
        end else if (!i_enable || w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ds_periodic_packetizer.sv
// Frames one BEATS-long packet per period onto a valid/ready data stream.
// It also counts the packets it has sent and the periods it has had to skip.
module ds_periodic_packetizer
    import ds_pkt_pkg::*;
#(
    parameter int DATA_WIDTH    = 256,
    parameter int ADDR_WIDTH    = 4,
    parameter int PERIOD_CYCLES = 1000,
    parameter int BEATS         = 4
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_enable,
    input  logic [ADDR_WIDTH-1:0] i_dest_addr,
    output logic                  o_tx_valid,
    output logic                  o_tx_sop,
    output logic                  o_tx_eop,
    output logic [ADDR_WIDTH-1:0] o_tx_addr,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    input  logic                  i_tx_ready,
    output logic [15:0]           o_pkt_count,
    output logic [15:0]           o_overrun_count,
    output logic                  o_busy
);
    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

    state_t                r_state, w_state_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_sop, w_sop_nxt;
    logic                  r_eop, w_eop_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic [7:0]            r_seq, w_seq_nxt;
    logic [3:0]            r_beat, w_beat_nxt;
    logic [15:0]           r_pkt, w_pkt_nxt;
    logic [15:0]           r_ovr, w_ovr_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  w_tick;
    logic                  w_xfer;
    logic [3:0]            w_beat_inc;

    ds_period_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_timer (
        .i_clk   (i_clk),
        .i_resetn(i_resetn),
        .i_enable(i_enable),
        .o_tick  (w_tick)
    );

    assign w_xfer     = r_valid & i_tx_ready;
    assign w_beat_inc = r_beat + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_sop_nxt   = r_sop;
        w_eop_nxt   = r_eop;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_seq_nxt   = r_seq;
        w_beat_nxt  = r_beat;
        w_pkt_nxt   = r_pkt;
        w_ovr_nxt   = r_ovr;

        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_state_nxt      = SEND;
                    w_valid_nxt      = 1'b1;
                    w_sop_nxt        = 1'b1;
                    w_eop_nxt        = (BEATS == 1);
                    w_addr_nxt       = i_dest_addr;
                    w_beat_nxt       = 4'd0;
                    w_data_nxt       = '0;
                    w_data_nxt[31:0] = beat_word(r_seq, 4'd0, r_pkt);
                end
            end
            SEND: begin
                // A tick that lands on the final transfer cycle also counts as a skipped period.
                if (w_tick && r_ovr != 16'hFFFF) begin
                    w_ovr_nxt = r_ovr + 16'd1;
                end
                if (w_xfer) begin
                    if (r_beat == LAST_BEAT) begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                        w_sop_nxt   = 1'b0;
                        w_eop_nxt   = 1'b0;
                        w_seq_nxt   = r_seq + 8'd1;
                        w_pkt_nxt   = r_pkt + 16'd1;
                    end else begin
                        w_beat_nxt       = w_beat_inc;
                        w_sop_nxt        = 1'b0;
                        w_eop_nxt        = (w_beat_inc == LAST_BEAT);
                        w_data_nxt       = '0;
                        w_data_nxt[31:0] = beat_word(r_seq, w_beat_inc, r_pkt);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_busy_nxt = (w_state_nxt == SEND);
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_seq   <= '0;
            r_beat  <= '0;
            r_pkt   <= '0;
            r_ovr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_sop   <= w_sop_nxt;
            r_eop   <= w_eop_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_seq   <= w_seq_nxt;
            r_beat  <= w_beat_nxt;
            r_pkt   <= w_pkt_nxt;
            r_ovr   <= w_ovr_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign o_tx_valid      = r_valid;
    assign o_tx_sop        = r_sop;
    assign o_tx_eop        = r_eop;
    assign o_tx_addr       = r_addr;
    assign o_tx_data       = r_data;
    assign o_pkt_count     = r_pkt;
    assign o_overrun_count = r_ovr;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_ds_periodic_packetizer.sv
// Scoreboard bench for ds_periodic_packetizer. The packet-level model queues every beat of a packet at launch.
// The monitor pops and compares one queued beat on each handshake it sees.
module tb_ds_periodic_packetizer;
    localparam int DW = 256;
    localparam int AW = 4;
    localparam int P  = 8;
    localparam int NB = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] dest_addr = '0;
    logic          ready = 1'b1;
    logic          tx_valid, tx_sop, tx_eop, busy;
    logic [AW-1:0] tx_addr;
    logic [DW-1:0] tx_data;
    logic [15:0]   pkt_count, overrun_count;

    int checks = 0;
    int passed = 0;

    ds_periodic_packetizer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PERIOD_CYCLES(P), .BEATS(NB)
    ) dut (
        .i_clk(clk), .i_resetn(resetn), .i_enable(enable), .i_dest_addr(dest_addr),
        .o_tx_valid(tx_valid), .o_tx_sop(tx_sop), .o_tx_eop(tx_eop),
        .o_tx_addr(tx_addr), .o_tx_data(tx_data), .i_tx_ready(ready),
        .o_pkt_count(pkt_count), .o_overrun_count(overrun_count), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model, written at the packet level.
    beat_t exp_q[$];
    int    m_phase = 0;
    bit    m_sending = 0;
    int    m_left = 0;
    int    m_seq = 0;
    int    m_pkts = 0;
    int    m_ovr = 0;

    always @(posedge clk) begin
        bit tick;
        beat_t b;
        if (!resetn) begin
            m_phase = 0; m_sending = 0; m_left = 0;
            m_seq = 0; m_pkts = 0; m_ovr = 0;
            exp_q.delete();
        end else begin
            tick = enable && (m_phase == P - 1);
            m_phase = enable ? (m_phase + 1) % P : 0;
            if (m_sending) begin
                if (tick && m_ovr < 65535) m_ovr++;
                if (ready) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_sending = 0;
                        m_seq = (m_seq + 1) % 256;
                        m_pkts = (m_pkts + 1) % 65536;
                    end
                end
            end else if (tick) begin
                m_sending = 1;
                m_left = NB;
                for (int i = 0; i < NB; i++) begin
                    b.addr = dest_addr;
                    b.data = '0;
                    b.data[31:0] = m_pkts * 65536 + 32'hA000 + i * 256 + m_seq;
                    b.sop = (i == 0);
                    b.eop = (i == NB - 1);
                    exp_q.push_back(b);
                end
            end
        end
    end

    // Monitor: outputs are sampled on the falling edge, midway between active edges.
    logic          pv_hold = 1'b0;
    logic          pv_sop, pv_eop;
    logic [AW-1:0] pv_addr;
    logic [DW-1:0] pv_data;

    always @(negedge clk) begin
        beat_t e;
        check("valid", tx_valid, m_sending);
        check("busy", busy, m_sending);
        check("pkt_count", pkt_count, 16'(m_pkts));
        check("overrun_count", overrun_count, 16'(m_ovr));
        if (pv_hold) begin
            check("hold_valid", tx_valid, 1'b1);
            check("hold_beat", {tx_sop, tx_eop, tx_addr, tx_data[31:0]},
                  {pv_sop, pv_eop, pv_addr, pv_data[31:0]});
        end
        if (tx_valid && ready && resetn) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("data_lo", tx_data[63:0], e.data[63:0]);
                check("data_hi_zero", 64'(tx_data[DW-1:64] != '0), 64'd0);
                check("addr", tx_addr, e.addr);
                check("sop", tx_sop, e.sop);
                check("eop", tx_eop, e.eop);
            end
        end
        pv_hold = tx_valid && !ready && resetn;
        pv_sop = tx_sop; pv_eop = tx_eop; pv_addr = tx_addr; pv_data = tx_data;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sop(input string name);
        int n = 0;
        while (!(tx_valid && tx_sop) && n < 60) begin
            step();
            n++;
        end
        if (!(tx_valid && tx_sop)) check(name, 64'(n), 64'd60 - 1);
    endtask

    initial begin
        int n;
        int ovr0;
        step(3);
        check("reset_valid", tx_valid, 1'b0);
        check("reset_data", tx_data[63:0], 64'd0);
        check("reset_addr", tx_addr, '0);
        resetn = 1'b1;
        step();

        // First packet launches eight edges after enable.
        enable = 1'b1; dest_addr = 4'd2; ready = 1'b1;
        n = 0;
        while (!tx_valid && n < 20) begin
            step();
            n++;
        end
        check("first_sop_latency", 64'(n), 64'd8);
        step(30);

        // Backpressure pattern 1,0,0,1.
        for (int i = 0; i < 64; i++) begin
            ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        ready = 1'b1;
        step(10);

        // Overrun: ready held low for 20 cycles from the start of a packet.
        wait_sop("wait_sop_overrun");
        ovr0 = overrun_count;
        ready = 1'b0;
        step(20);
        check("overrun_delta", 64'(overrun_count - 16'(ovr0)), 64'd2);
        ready = 1'b1;
        step(30);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 15) != 0);
            dest_addr = 4'($urandom);
            step();
        end
        enable = 1'b1; ready = 1'b1;

        // Enough periods for the sequence value to wrap.
        step(256 * P + 20);

        // Dropping enable mid-packet lets the current packet finish and suppresses later launches.
        wait_sop("wait_sop_enable");
        step();
        enable = 1'b0;
        step(40);
        check("idle_after_disable", tx_valid, 1'b0);
        enable = 1'b1;

        // Reset while beat 2 is presented.
        wait_sop("wait_sop_reset");
        step(2);
        resetn = 1'b0;
        step();
        check("reset_mid_valid", tx_valid, 1'b0);
        check("reset_mid_counts", {pkt_count, overrun_count}, 32'd0);
        resetn = 1'b1;
        wait_sop("wait_sop_after_reset");
        check("seq_after_reset", tx_data[7:0], 8'd0);
        step(20);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ds_periodic_packetizer.md
Name: ds_periodic_packetizer

Overview:
- Upstream source for the data-streaming NoC path; drives the tx side of a vertical NAP.
- Every PERIOD_CYCLES it frames one multi-beat packet and presents it on a t_DATA_STREAM with valid/ready, sop/eop and a destination address.
- Packets carry an 8-bit sequence value that the downstream LED receiver displays.
- Counts sent packets and missed periods, exposing both for Snapshot monitoring.

Parameters:
- DATA_WIDTH, 256: tx.data width; equals NAP horizontal data width; must be ≥ 32.
- ADDR_WIDTH, 4: tx.addr width; equals NAP data-stream address width.
- PERIOD_CYCLES, 1000: clk cycles between packet launches; must be ≥ 2.
- BEATS, 4: beats per packet, 1..16.

Ports:
- clk  in  1  sole clock.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  1 = launch packets on period ticks; 0 = no new launches.
- dest_addr  in  ADDR_WIDTH  NoC destination; sampled at packet launch.
- tx  t_DATA_STREAM (transmit side)  —  drives valid, sop, eop, addr, data; samples ready.
- pkt_count  out  16  packets fully sent; wraps modulo 2^16.
- overrun_count  out  16  period ticks dropped because a packet was still in flight; saturates at 16'hFFFF.
- busy  out  1  1 while state = SEND.

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, tx.valid=0, tx.sop=0, tx.eop=0, tx.addr=0, tx.data=0, seq=0, beat=0, period timer=0, pkt_count=0, overrun_count=0, busy=0. Reset mid-packet abandons the packet immediately; no eop is emitted.
- Period timer:
  - Free-runs 0..PERIOD_CYCLES-1 while enable=1; tick when the timer equals PERIOD_CYCLES-1, then it wraps to 0.
  - Held at 0 while enable=0.
- State IDLE:
  - On tick, go to SEND next cycle.
  - Registered outputs that cycle: valid=1, sop=1, eop=(BEATS==1), addr=dest_addr latched, data=beat0.
  - Launch latency: 1 cycle from tick.
- State SEND:
  - A beat transfers when valid & ready.
  - On transfer of a non-last beat: beat++, present the next beat next cycle with sop=0 and eop=(beat==BEATS-1).
  - On transfer of the last beat: valid=0, sop=0, eop=0, seq++ (8-bit wrap), pkt_count++, return to IDLE.
  - No bubbles while ready=1: back-to-back beats.
- Handshake rules:
  - Once valid=1, valid/sop/eop/addr/data hold stable until ready.
  - valid never drops mid-packet, even if enable goes 0. enable=0 only suppresses future launches.
- Beat payload:
  - data[7:0]=seq, data[11:8]=beat index, data[15:12]=4'hA marker, data[31:16]=pkt_count value at launch.
  - All higher bits are 0.
- Overrun:
  - A tick while state=SEND, or coincident with the last-beat transfer cycle, increments overrun_count; that period's packet is skipped.
  - A tick in IDLE always launches.
- Address: dest_addr is latched at launch; changes mid-packet do not affect the in-flight packet.
- busy = (state==SEND), registered.

Decomposition:
- Shared package ds_pkt_pkg holds:
  - state enum {IDLE, SEND};
  - payload field offsets: SEQ_LSB=0, BEAT_LSB=8, MARK_LSB=12, CNT_LSB=16;
  - MARKER=4'hA.
- One natural sub-module, ds_period_timer: period counter with enable producing a 1-cycle tick. Framing FSM and counters stay in the top.

Test Plan:
- Reset release, PERIOD_CYCLES=8, BEATS=4, ready=1, dest_addr=2 → first sop at cycle 8 after enable. Four consecutive beats with data[11:8]=0,1,2,3; eop on beat 3; addr=2; data[7:0]=0; pkt_count=1.
- Backpressure: ready toggles 1,0,0,1 each beat → every beat held stable while ready=0, no beat lost or duplicated, and eop is seen exactly once.
- Overrun: ready=0 held for 20 cycles with PERIOD_CYCLES=8 → overrun_count=2. Packet completes after ready returns; next packet carries seq=1.
- Wrap: run 256 packets → seq returns to 0 and pkt_count=256.
- enable dropped mid-packet → the current packet finishes with eop, and no further sop appears while enable=0.
- resetn asserted on beat 2 → next cycle valid=0 with all counters 0. The first packet after release starts at sop with seq=0.
